// File: rtl/instruction_loader_pkg.sv
// ---------------------------------------------------------------------------
// instruction_loader_pkg
//
// Shared definitions for the instruction loader and the blocks around it
// (fetch side and instruction store). Holds the default word width, store
// depth, derived address width and the loader state enumeration.
// ---------------------------------------------------------------------------
package instruction_loader_pkg;

    // Default instruction word width in bits.
    localparam int DATA_W_DEF = 16;

    // Default number of instruction-store entries.
    localparam int DEPTH_DEF  = 32;

    // Address width that covers DEPTH_DEF entries.
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    // Loader frame states.
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_e;

endpackage

// File: rtl/instruction_loader_xor_accumulator.sv
// ---------------------------------------------------------------------------
// xor_accumulator
//
// Running XOR of every word presented while enable_i is high. clear_i
// returns the value to zero and takes priority over enable_i.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   clear_i   - synchronous clear of the running value
//   enable_i  - fold data_i into the running value this cycle
//   data_i    - word to fold in
//   value_o   - current running XOR
// ---------------------------------------------------------------------------
module xor_accumulator #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    // Next value: clear wins over a fold so a new frame always starts at 0.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            acc_d = acc_q ^ data_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign value_o = acc_q;

endmodule

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//
// Receives a framed instruction stream (length N, N instruction words,
// XOR checksum) over a valid/ready handshake and writes the instructions
// into the instruction store, holding the CPU fetch side while loading.
//
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous active-low reset
//   start          - one-cycle request to begin a frame
//   in_valid       - source offers in_data
//   in_data        - incoming frame word
//   in_ready       - loader accepts a word this cycle
//   wr_en          - instruction-store write strobe
//   wr_addr        - instruction-store write address
//   wr_data        - instruction-store write data
//   cpu_hold       - holds the fetch-side PC in reset
//   busy           - frame in progress
//   done           - sticky: frame finished with a good checksum
//   error          - sticky: bad length or checksum mismatch
//   words_loaded   - instruction words written in the current/last frame
// ---------------------------------------------------------------------------
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int               LEN_W   = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [LEN_W-1:0]  words_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              done_q;
    logic              error_q;

    logic              accept;
    logic              startOk;
    logic              lenOk;
    logic              lastWord;
    logic              chkMatch;
    logic [DATA_W-1:0] chkValue;

    // A start is honoured only between frames; mid-frame starts are dropped.
    assign startOk  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign accept   = in_valid && in_ready;
    assign lenOk    = (in_data != '0) && (in_data <= DATA_W'(DEPTH));
    assign lastWord = (words_q + LEN_W'(1)) == len_q;
    assign chkMatch = (in_data == chkValue);

    // Running checksum over the instruction words of the current frame.
    xor_accumulator #(
        .W (DATA_W)
    ) u_xor (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (startOk),
        .enable_i (accept && state_q == DATA),
        .data_i   (in_data),
        .value_o  (chkValue)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each frame phase advances only on an accepted word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERR: if (start)  state_d = HDR;
            HDR:  if (accept) state_d = lenOk ? DATA : ERR;
            DATA: if (accept && lastWord) state_d = CHK;
            CHK:  if (accept) state_d = chkMatch ? DONE : ERR;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; the CPU stays held after an error so a bad
    // image is never executed.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        unique case (state_q)
            HDR, DATA, CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            ERR:     cpu_hold = 1'b1;
            default: ;
        endcase
    end

    // Datapath: write port register, index, counters and sticky flags.
    // The write strobe is registered, giving one cycle from acceptance to
    // the store write. The index saturates at the last entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            idx_q     <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (startOk) begin
                idx_q   <= '0;
                words_q <= '0;
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (accept) begin
                unique case (state_q)
                    HDR: begin
                        if (lenOk) begin
                            len_q <= in_data[LEN_W-1:0];
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q;
                        wr_data_q <= in_data;
                        words_q   <= words_q + LEN_W'(1);
                        if (idx_q != IDX_MAX) begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                    CHK: begin
                        if (chkMatch) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// ---------------------------------------------------------------------------
// tb_instruction_loader
//
// Directed bench for instruction_loader: good frame, bad checksum, bad
// lengths, full-depth frame with a stalling source, mid-frame reset and a
// start pulse during DATA. Store writes are logged by a monitor and checked
// against hand-computed address/data lists.
// ---------------------------------------------------------------------------
module tb_instruction_loader;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int assertCount;
    int failCount;

    // Write log filled by the monitor below.
    logic [ADDR_W-1:0] wrAddrLog[$];
    logic [DATA_W-1:0] wrDataLog[$];

    instruction_loader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every store write, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wrAddrLog.push_back(wr_addr);
            wrDataLog.push_back(wr_data);
        end
    end

    // One immediate-assertion comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle.
    task automatic doStart();
        start = 1'b1;
        stepClock();
        start = 1'b0;
    endtask

    // Offer one word and wait (bounded) until the loader takes it; returns
    // just after the accepting edge with in_valid still high.
    task automatic applyStimulus(input string tag, input logic [DATA_W-1:0] word);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = word;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                taken = 1'b1;
            end
            stepClock();
        end
        checkOutput({tag, " accepted"}, 32'(taken), 32'd1);
    endtask

    // Compare the write log against an expected address/data list.
    task automatic checkWrites(input string tag, input int expCount,
                               input logic [DATA_W-1:0] expData[$]);
        checkOutput({tag, " write count"}, 32'(wrAddrLog.size()), 32'(expCount));
        for (int i = 0; i < expCount && i < wrAddrLog.size(); i++) begin
            checkOutput($sformatf("%s addr[%0d]", tag, i), 32'(wrAddrLog[i]), 32'(i));
            checkOutput($sformatf("%s data[%0d]", tag, i), 32'(wrDataLog[i]), 32'(expData[i]));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] expData[$];

        assertCount = 0;
        failCount   = 0;
        reset       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;

        // ---- Reset state -------------------------------------------------
        stepClock();
        stepClock();
        checkOutput("rst in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst error", 32'(error), 32'd0);
        checkOutput("rst wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst words", 32'(words_loaded), 32'd0);
        reset = 1'b1;
        stepClock();
        checkOutput("idle in_ready", 32'(in_ready), 32'd0);

        // ---- Good 3-word frame, valid held high ---------------------------
        $display("[TB] good frame");
        wrAddrLog.delete(); wrDataLog.delete();
        doStart();
        checkOutput("good busy", 32'(busy), 32'd1);
        checkOutput("good hold", 32'(cpu_hold), 32'd1);
        checkOutput("good in_ready", 32'(in_ready), 32'd1);
        applyStimulus("good len", 16'd3);
        checkOutput("good no wr after len", 32'(wr_en), 32'd0);
        applyStimulus("good w0", 16'h1111);
        checkOutput("good w0 wr_en", 32'(wr_en), 32'd1);
        checkOutput("good w0 addr", 32'(wr_addr), 32'd0);
        checkOutput("good w0 data", 32'(wr_data), 32'h1111);
        applyStimulus("good w1", 16'h2222);
        checkOutput("good w1 addr", 32'(wr_addr), 32'd1);
        applyStimulus("good w2", 16'h4444);
        checkOutput("good w2 data", 32'(wr_data), 32'h4444);
        applyStimulus("good chk", 16'h7777);
        in_valid = 1'b0;
        checkOutput("good chk wr_en", 32'(wr_en), 32'd0);
        checkOutput("good done", 32'(done), 32'd1);
        checkOutput("good error", 32'(error), 32'd0);
        checkOutput("good words", 32'(words_loaded), 32'd3);
        checkOutput("good hold off", 32'(cpu_hold), 32'd0);
        checkOutput("good busy off", 32'(busy), 32'd0);
        stepClock();
        expData = '{16'h1111, 16'h2222, 16'h4444};
        checkWrites("good", 3, expData);

        // ---- Bad checksum -------------------------------------------------
        $display("[TB] bad checksum");
        wrAddrLog.delete(); wrDataLog.delete();
        doStart();
        checkOutput("badchk done cleared", 32'(done), 32'd0);
        applyStimulus("badchk len", 16'd3);
        applyStimulus("badchk w0", 16'h1111);
        applyStimulus("badchk w1", 16'h2222);
        applyStimulus("badchk w2", 16'h4444);
        applyStimulus("badchk chk", 16'h7776);
        in_valid = 1'b0;
        checkOutput("badchk error", 32'(error), 32'd1);
        checkOutput("badchk done", 32'(done), 32'd0);
        checkOutput("badchk hold", 32'(cpu_hold), 32'd1);
        checkOutput("badchk busy", 32'(busy), 32'd0);
        checkOutput("badchk words", 32'(words_loaded), 32'd3);
        stepClock();
        checkWrites("badchk", 3, expData);

        // ---- Bad lengths 0 and 33 -----------------------------------------
        $display("[TB] bad lengths");
        wrAddrLog.delete(); wrDataLog.delete();
        doStart();
        checkOutput("len0 error cleared", 32'(error), 32'd0);
        applyStimulus("len0 len", 16'd0);
        checkOutput("len0 error", 32'(error), 32'd1);
        checkOutput("len0 in_ready", 32'(in_ready), 32'd0);
        checkOutput("len0 hold", 32'(cpu_hold), 32'd1);
        in_data = 16'h00AA;
        for (int i = 0; i < 4; i++) stepClock();
        doStart();
        applyStimulus("len33 len", 16'd33);
        in_valid = 1'b0;
        checkOutput("len33 error", 32'(error), 32'd1);
        checkOutput("len33 busy", 32'(busy), 32'd0);
        checkOutput("len33 words", 32'(words_loaded), 32'd0);
        stepClock();
        checkOutput("badlen write count", 32'(wrAddrLog.size()), 32'd0);

        // ---- Full depth with stalling source ------------------------------
        $display("[TB] full depth with stalls");
        wrAddrLog.delete(); wrDataLog.delete();
        expData.delete();
        doStart();
        applyStimulus("full len", 16'd32);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b0;
            stepClock();
            applyStimulus($sformatf("full w%0d", i), 16'(i));
            expData.push_back(16'(i));
        end
        in_valid = 1'b0;
        stepClock();
        checkOutput("full stall state busy", 32'(busy), 32'd1);
        checkOutput("full words", 32'(words_loaded), 32'd32);
        applyStimulus("full chk", 16'h0000);
        in_valid = 1'b0;
        checkOutput("full done", 32'(done), 32'd1);
        checkOutput("full error", 32'(error), 32'd0);
        stepClock();
        checkWrites("full", 32, expData);

        // ---- Reset mid-frame, then a clean reload -------------------------
        $display("[TB] mid-frame reset");
        wrAddrLog.delete(); wrDataLog.delete();
        doStart();
        applyStimulus("rstmid len", 16'd5);
        applyStimulus("rstmid w0", 16'h0A0A);
        applyStimulus("rstmid w1", 16'h0B0B);
        checkOutput("rstmid pre wr_en", 32'(wr_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rstmid wr_en", 32'(wr_en), 32'd0);
        checkOutput("rstmid busy", 32'(busy), 32'd0);
        checkOutput("rstmid hold", 32'(cpu_hold), 32'd0);
        checkOutput("rstmid in_ready", 32'(in_ready), 32'd0);
        checkOutput("rstmid words", 32'(words_loaded), 32'd0);
        checkOutput("rstmid addr", 32'(wr_addr), 32'd0);
        checkOutput("rstmid data", 32'(wr_data), 32'd0);
        wrAddrLog.delete(); wrDataLog.delete();
        in_data = 16'h0C0C;
        for (int i = 0; i < 3; i++) stepClock();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) stepClock();
        in_valid = 1'b0;
        checkOutput("rstmid no writes", 32'(wrAddrLog.size()), 32'd0);
        doStart();
        applyStimulus("reload len", 16'd3);
        applyStimulus("reload w0", 16'hA001);
        applyStimulus("reload w1", 16'hB002);
        applyStimulus("reload w2", 16'hC003);
        applyStimulus("reload chk", 16'hD000);
        in_valid = 1'b0;
        checkOutput("reload done", 32'(done), 32'd1);
        stepClock();
        expData = '{16'hA001, 16'hB002, 16'hC003};
        checkWrites("reload", 3, expData);

        // ---- Start pulse during DATA is ignored ---------------------------
        $display("[TB] start during DATA");
        wrAddrLog.delete(); wrDataLog.delete();
        doStart();
        applyStimulus("ign len", 16'd3);
        applyStimulus("ign w0", 16'h0100);
        start = 1'b1;
        applyStimulus("ign w1", 16'h0020);
        start = 1'b0;
        checkOutput("ign words mid", 32'(words_loaded), 32'd2);
        checkOutput("ign addr mid", 32'(wr_addr), 32'd1);
        applyStimulus("ign w2", 16'h0003);
        applyStimulus("ign chk", 16'h0123);
        in_valid = 1'b0;
        checkOutput("ign done", 32'(done), 32'd1);
        checkOutput("ign error", 32'(error), 32'd0);
        checkOutput("ign words", 32'(words_loaded), 32'd3);
        stepClock();
        expData = '{16'h0100, 16'h0020, 16'h0003};
        checkWrites("ign", 3, expData);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
